// File: rtl/sdp_rdma_gather.sv
// Width-up gatherer: packs OW-bit beats (with CW-bit ctrl) into IW-bit words.
// Ports: clk/rst, cfg_dp_8, inp_{pvld,prdy,data}, out_{pvld,prdy,data}.
module sdp_rdma_gather #(
  parameter int IW    = 512,
  parameter int CW    = 1,
  parameter int OW    = 128,
  parameter int RATIO = IW / OW
) (
  input  logic              nvdla_core_clk,
  input  logic              nvdla_core_rst,
  input  logic              cfg_dp_8,
  input  logic              inp_pvld,
  output logic              inp_prdy,
  input  logic [OW+CW-1:0]  inp_data,
  output logic              out_pvld,
  input  logic              out_prdy,
  output logic [IW+CW-1:0]  out_data
);

  localparam logic [3:0] LAST_FULL = 4'(RATIO - 1);
  localparam logic [3:0] LAST_HALF = 4'(RATIO / 2 - 1);

  logic [3:0]       r_beat_cnt;
  logic             r_dp8_lat;
  logic [IW-1:0]    r_asm;
  logic [IW+CW-1:0] r_out_data;
  logic             r_out_pvld;

  logic             w_first;
  logic             w_mode;
  logic             w_is_last;
  logic             w_inp_acc;
  logic             w_out_acc;
  logic [OW-1:0]    w_beat_data;
  logic [CW-1:0]    w_beat_ctrl;
  logic [IW-1:0]    w_asm_base;
  logic [IW-1:0]    w_asm_next;

  assign w_first     = (r_beat_cnt == 4'd0);
  // First beat of a word takes the live mode; later beats use the latch.
  assign w_mode      = w_first ? cfg_dp_8 : r_dp8_lat;
  assign w_is_last   = (r_beat_cnt == (w_mode ? LAST_FULL : LAST_HALF));
  assign w_beat_data = inp_data[OW-1:0];
  assign w_beat_ctrl = inp_data[OW +: CW];

  // Only a word-completing beat has to wait for the output register.
  assign inp_prdy  = !w_is_last | !r_out_pvld | out_prdy;
  assign w_inp_acc = inp_pvld & inp_prdy;
  assign w_out_acc = r_out_pvld & out_prdy;

  // Starting a word clears every segment so half-mode words pad with zeros.
  assign w_asm_base = w_first ? '0 : r_asm;

  always_comb begin
    w_asm_next = w_asm_base;
    for (int k = 0; k < RATIO; k++) begin
      if (r_beat_cnt == 4'(k)) begin
        w_asm_next[k*OW +: OW] = w_beat_data;
      end
    end
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      r_beat_cnt <= 4'd0;
      r_dp8_lat  <= 1'b0;
      r_asm      <= '0;
      r_out_data <= '0;
      r_out_pvld <= 1'b0;
    end else begin
      if (w_inp_acc) begin
        r_beat_cnt <= w_is_last ? 4'd0 : r_beat_cnt + 4'd1;
        r_asm      <= w_asm_next;
        if (w_first) begin
          r_dp8_lat <= cfg_dp_8;
        end
      end
      if (w_inp_acc && w_is_last) begin
        r_out_data <= {w_beat_ctrl, w_asm_next};
        r_out_pvld <= 1'b1;
      end else if (w_out_acc) begin
        r_out_pvld <= 1'b0;
      end
    end
  end

  assign out_pvld = r_out_pvld;
  assign out_data = r_out_data;

endmodule

// File: tb/tb_sdp_rdma_gather.sv
// Self-checking bench for sdp_rdma_gather: directed steps plus random traffic
// compared against a queue-based word-assembly model.
module tb_sdp_rdma_gather;

  localparam int IW    = 512;
  localparam int CW    = 1;
  localparam int OW    = 128;
  localparam int RATIO = IW / OW;
  localparam int W     = IW + CW;

  logic             clk = 1'b0;
  logic             rst;
  logic             cfg;
  logic             ipv;
  logic             iprdy;
  logic [OW+CW-1:0] idata;
  logic             opv;
  logic             oprdy;
  logic [W-1:0]     odata;

  always #5 clk = ~clk;

  sdp_rdma_gather #(.IW(IW), .CW(CW), .OW(OW)) dut (
    .nvdla_core_clk (clk),
    .nvdla_core_rst (rst),
    .cfg_dp_8       (cfg),
    .inp_pvld       (ipv),
    .inp_prdy       (iprdy),
    .inp_data       (idata),
    .out_pvld       (opv),
    .out_prdy       (oprdy),
    .out_data       (odata)
  );

  int n_pass = 0;
  int n_chk  = 0;

  logic [OW-1:0] cur_d[$];
  bit            cur_mode;
  logic [W-1:0]  expq[$];
  bit            last_acc;
  bit            obs_prdy;
  int            prdy_lows;
  int            words_out;

  task automatic chk(string tag, logic [W-1:0] obs, logic [W-1:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic int nb(bit m);
    return m ? RATIO : RATIO / 2;
  endfunction

  function automatic logic [OW-1:0] rep(logic [7:0] b);
    return {16{b}};
  endfunction

  function automatic logic [OW-1:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [W-1:0] build(logic [CW-1:0] c);
    logic [W-1:0] w;
    w = '0;
    foreach (cur_d[i]) w[i*OW +: OW] = cur_d[i];
    w[IW +: CW] = c;
    return w;
  endfunction

  task automatic tick();
    bit m, exp_pv, exp_prdy, acc_o, acc_i;
    @(negedge clk);
    last_acc = 1'b0;
    if (rst) begin
      cur_d.delete();
      expq.delete();
    end else begin
      m        = (cur_d.size() == 0) ? cfg : cur_mode;
      exp_pv   = (expq.size() != 0);
      exp_prdy = (cur_d.size() + 1 != nb(m)) || !exp_pv || oprdy;
      obs_prdy = iprdy;
      if (!iprdy) prdy_lows++;
      chk("out_pvld", W'(opv), W'(exp_pv));
      chk("inp_prdy", W'(iprdy), W'(exp_prdy));
      if (exp_pv) chk("out_data", odata, expq[0]);
      acc_o = exp_pv && oprdy;
      acc_i = ipv && exp_prdy;
      if (acc_o) begin
        void'(expq.pop_front());
        words_out++;
      end
      if (acc_i) begin
        if (cur_d.size() == 0) cur_mode = cfg;
        cur_d.push_back(idata[OW-1:0]);
        if (cur_d.size() == nb(cur_mode)) begin
          expq.push_back(build(idata[OW +: CW]));
          cur_d.delete();
        end
        last_acc = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(logic [OW-1:0] d, logic [CW-1:0] c);
    int n;
    n     = 0;
    ipv   = 1'b1;
    idata = {c, d};
    do begin
      tick();
      n++;
    end while (!last_acc && n < 50);
    chk("beat_timeout", W'(last_acc), W'(1));
    ipv = 1'b0;
  endtask

  task automatic drain();
    oprdy = 1'b1;
    tick();
    tick();
  endtask

  initial begin
    rst = 1'b1; cfg = 1'b1; ipv = 1'b0; oprdy = 1'b1; idata = '0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_pvld", W'(opv), W'(0));
    chk("rst_data", odata, W'(0));
    chk("rst_prdy", W'(iprdy), W'(1));

    // 1: full word, dp8=1
    prdy_lows = 0;
    send(rep(8'h11), 1'b0);
    send(rep(8'h22), 1'b0);
    send(rep(8'h33), 1'b0);
    send(rep(8'h44), 1'b1);
    chk("t1_pvld", W'(opv), W'(1));
    chk("t1_word", odata,
        {1'b1, rep(8'h44), rep(8'h33), rep(8'h22), rep(8'h11)});
    chk("t1_prdy_lows", W'(prdy_lows), W'(0));

    // 2: half mode, upper half zero, no residue
    cfg = 1'b0;
    send(rep(8'hA1), 1'b0);
    send(rep(8'hB2), 1'b1);
    chk("t2_word_ab", odata, {1'b1, 256'h0, rep(8'hB2), rep(8'hA1)});
    send(rep(8'hC3), 1'b1);
    send(rep(8'hD4), 1'b0);
    chk("t2_word_cd", odata, {1'b0, 256'h0, rep(8'hD4), rep(8'hC3)});

    // 3: stalled output, last beat back-pressured
    drain();
    cfg = 1'b1;
    oprdy = 1'b0;
    send(rep(8'h01), 1'b0);
    send(rep(8'h02), 1'b0);
    send(rep(8'h03), 1'b0);
    send(rep(8'h04), 1'b0);
    send(rep(8'h05), 1'b0);
    send(rep(8'h06), 1'b0);
    send(rep(8'h07), 1'b0);
    ipv = 1'b1;
    idata = {1'b1, rep(8'h08)};
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t3_stall", W'(obs_prdy), W'(0));
    end
    oprdy = 1'b1;
    tick();
    ipv = 1'b0;
    chk("t3_acc", W'(last_acc), W'(1));
    chk("t3_pvld", W'(opv), W'(1));
    chk("t3_word2", odata,
        {1'b1, rep(8'h08), rep(8'h07), rep(8'h06), rep(8'h05)});

    // 4: mode change mid-word is deferred
    drain();
    cfg = 1'b1;
    send(rep(8'h61), 1'b0);
    send(rep(8'h62), 1'b0);
    cfg = 1'b0;
    send(rep(8'h63), 1'b0);
    chk("t4_not_done", W'(opv), W'(0));
    send(rep(8'h64), 1'b1);
    chk("t4_word4", odata,
        {1'b1, rep(8'h64), rep(8'h63), rep(8'h62), rep(8'h61)});
    send(rep(8'h65), 1'b0);
    send(rep(8'h66), 1'b0);
    chk("t4_word2", odata, {1'b0, 256'h0, rep(8'h66), rep(8'h65)});

    // 5: reset mid-word
    drain();
    cfg = 1'b1;
    send(rep(8'hE1), 1'b0);
    send(rep(8'hE2), 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_pvld", W'(opv), W'(0));
    chk("t5_data", odata, W'(0));
    send(rep(8'h71), 1'b0);
    send(rep(8'h72), 1'b0);
    chk("t5_partial", W'(opv), W'(0));
    send(rep(8'h73), 1'b0);
    send(rep(8'h74), 1'b1);
    chk("t5_word", odata,
        {1'b1, rep(8'h74), rep(8'h73), rep(8'h72), rep(8'h71)});

    // 6: continuous stream, 40 beats
    drain();
    prdy_lows = 0;
    words_out = 0;
    cfg = 1'b1;
    for (int i = 0; i < 40; i++) send(rnd128(), CW'($urandom));
    tick();
    tick();
    chk("t6_prdy_lows", W'(prdy_lows), W'(0));
    chk("t6_words", W'(words_out), W'(10));

    // random traffic
    ipv = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (!ipv || last_acc) begin
        ipv   = ($urandom_range(0, 3) != 0);
        idata = {CW'($urandom), rnd128()};
      end
      cfg   = $urandom_range(0, 1) == 1;
      oprdy = $urandom_range(0, 2) != 0;
      tick();
    end
    ipv = 1'b0;
    drain();
    chk("end_empty", W'(opv), W'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
